cmac_accum_sign: RTL and testbench
==================================

// Module: cmac_accum_sign
// PURPOSE
//  Downstream stage of the signed complex multiplier: accumulates a stream of sign-magnitude complex
//  products into one complex sum (row . state-vector dot product for a gate application in the QFT
//  datapath). valid/ready on both sides; one result per frame; sticky overflow aggregation.
// PARAMETERS
//  DATA_W   32  word width; bit DATA_W-1 = sign, bits DATA_W-2:0 = magnitude (sign-magnitude)
//  N_TERMS  16  max products per frame; frame closes at N_TERMS accepted beats if in_last never seen
//  GUARD_W  4   extra internal magnitude bits; elaboration error if N_TERMS > 2**GUARD_W
// PORTS
//  clk           in   1                 rising-edge clock
//  rst           in   1                 async, active-high reset
//  in_valid      in   1                 product beat valid
//  in_ready      out  1                 stage can accept a beat
//  in_real       in   DATA_W            product real part (sign-magnitude)
//  in_img        in   DATA_W            product imaginary part (sign-magnitude)
//  in_ovf        in   1                 overflow flag from the multiplier for this beat
//  in_last       in   1                 beat is final term of frame
//  out_valid     out  1                 result valid
//  out_ready     in   1                 consumer accepts result
//  out_real      out  DATA_W            accumulated real part (sign-magnitude)
//  out_img       out  DATA_W            accumulated imaginary part (sign-magnitude)
//  out_overflow  out  1                 any overflow in this frame
//  out_count     out  $clog2(N_TERMS+1) number of terms accumulated
// BEHAVIOUR
//  - Reset (async, any state, mid-frame included): state IDLE, accumulators, count, sticky flag = 0;
//    out_valid=0, out_real=out_img=0, out_overflow=0, out_count=0. Partial frame discarded.
//  - States: IDLE (no frame open), ACC (frame open), HOLD (result presented).
//    in_ready = (state != HOLD); combinational from state only.
//  - Accept = in_valid & in_ready. IDLE+accept: acc <= beat, count<=1, sticky<=in_ovf -> ACC.
//    ACC+accept: acc <= acc + beat, count++, sticky |= in_ovf. No accept: state and acc hold.
//  - Frame closes on an accepted beat with in_last=1 or count reaching N_TERMS (either; both same).
//    Closing beat is included; results registered same edge -> HOLD, out_valid=1 next cycle
//    (latency 1 cycle from closing accept). Single-beat frame with in_last from IDLE is legal.
//  - HOLD: out_* stable until out_valid & out_ready; then -> IDLE, out_valid=0, in_ready=1 the
//    following cycle (one bubble per frame; no same-cycle accept in HOLD).
//  - Arithmetic: per component, sign-magnitude add in DATA_W-1+GUARD_W magnitude bits: equal signs
//    add magnitudes; differing signs subtract smaller from larger, sign of larger. -0 input treated
//    as +0; magnitude 0 always yields sign 0 (never emit 0x8..0). Real and img independent.
//  - Output conversion: if |acc| > 2**(DATA_W-1)-1 on either component -> range overflow; output
//    magnitude handling per CONFIGURATION; sign preserved.
//  - out_overflow = sticky in_ovf | range overflow (real or img). Cleared when next frame opens.
// CONFIGURATION
//  CMAC_ACCUM_SAT_EN defined: overflowing component outputs max magnitude {sign, all-ones}.
//  Not defined: overflowing component outputs {sign, low DATA_W-1 magnitude bits} (wrap);
//  if the wrapped magnitude is 0, sign forced to 0. out_overflow identical in both builds.
// TESTING  (DATA_W=16, N_TERMS=4, GUARD_W=4)
//  1 beats (0x0003,0x0002),(0x8005,0x8001),(0x0001,0x0000) last on 3rd -> out 0x8001/0x0001,
//    count 3, overflow 0, out_valid one cycle after 3rd accept.
//  2 four beats real 0x4000, img 0x0000, no last -> closes at 4; overflow 1; real 0x0000 (wrap)
//    or 0x7FFF (CMAC_ACCUM_SAT_EN); img 0x0000; count 4.
//  3 beats real 0x0007 then 0x8007 last -> out_real 0x0000 (not 0x8000), overflow 0.
//  4 out_ready low 5 cycles in HOLD with in_valid pulsing -> out_* stable, in_ready 0, no beats
//    consumed; out_ready high -> handshake, in_ready 1 next cycle, next frame unaffected.
//  5 frame of 2 beats with in_ovf=1 on 1st, sum 0x0004 -> out_overflow 1; next frame clean -> 0.
//  6 rst pulsed after 2 accepted beats -> all outputs 0, in_ready 1; then single beat 0x0009 last
//    -> out_real 0x0009, count 1, overflow 0.

Source files
------------

// File: rtl/cmac_accum_sign.sv
// Sign-magnitude complex accumulator: sums a frame of complex products into one result.
// Define CMAC_ACCUM_SAT_EN to saturate out-of-range results; otherwise they wrap.
module cmac_accum_sign #(
    parameter int DATA_W  = 32,
    parameter int N_TERMS = 16,
    parameter int GUARD_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_real,
    input  logic [DATA_W-1:0]            in_img,
    input  logic                         in_ovf,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_real,
    output logic [DATA_W-1:0]            out_img,
    output logic                         out_overflow,
    output logic [$clog2(N_TERMS+1)-1:0] out_count
);
    localparam int MAG_W = DATA_W - 1 + GUARD_W;
    localparam int CNT_W = $clog2(N_TERMS + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    generate
        if (N_TERMS > 2 ** GUARD_W) begin : g_guard_check
            $error("cmac_accum_sign: N_TERMS exceeds 2**GUARD_W");
        end
    endgenerate

    // Internal accumulator format: {sign, MAG_W-bit magnitude}; zero is always +0.
    function automatic logic [MAG_W:0] sm_norm(input logic [DATA_W-1:0] w);
        logic [MAG_W-1:0] m;
        m = MAG_W'(w[DATA_W-2:0]);
        return {w[DATA_W-1] & (|m), m};
    endfunction

    function automatic logic [MAG_W:0] sm_add(input logic [MAG_W:0] a, input logic [MAG_W:0] b);
        logic [MAG_W-1:0] m;
        logic             s;
        if (a[MAG_W] == b[MAG_W]) begin
            m = a[MAG_W-1:0] + b[MAG_W-1:0];
            s = a[MAG_W];
        end else if (a[MAG_W-1:0] >= b[MAG_W-1:0]) begin
            m = a[MAG_W-1:0] - b[MAG_W-1:0];
            s = a[MAG_W];
        end else begin
            m = b[MAG_W-1:0] - a[MAG_W-1:0];
            s = b[MAG_W];
        end
        return {s & (|m), m};
    endfunction

    function automatic logic range_ovf(input logic [MAG_W:0] a);
        return |a[MAG_W-1:DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] to_out(input logic [MAG_W:0] a);
        logic [DATA_W-2:0] lo;
        lo = a[DATA_W-2:0];
`ifdef CMAC_ACCUM_SAT_EN
        if (range_ovf(a))
            return {a[MAG_W], {(DATA_W-1){1'b1}}};
        return {a[MAG_W], lo};
`else
        // Wrapped magnitude of zero must not carry a sign.
        return {a[MAG_W] & (|lo), lo};
`endif
    endfunction

    logic [1:0]       state;
    logic [MAG_W:0]   acc_re, acc_im;
    logic [CNT_W-1:0] cnt;
    logic             sticky;

    logic             accept, close, nxt_sticky;
    logic [MAG_W:0]   nxt_re, nxt_im;
    logic [CNT_W-1:0] nxt_cnt;

    assign in_ready = (state != HOLD);
    assign accept   = in_valid & in_ready;

    always_comb begin
        if (state == IDLE) begin
            nxt_re     = sm_norm(in_real);
            nxt_im     = sm_norm(in_img);
            nxt_cnt    = CNT_W'(1);
            nxt_sticky = in_ovf;
        end else begin
            nxt_re     = sm_add(acc_re, sm_norm(in_real));
            nxt_im     = sm_add(acc_im, sm_norm(in_img));
            nxt_cnt    = cnt + CNT_W'(1);
            nxt_sticky = sticky | in_ovf;
        end
        close = in_last | (nxt_cnt == CNT_W'(N_TERMS));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            acc_re       <= '0;
            acc_im       <= '0;
            cnt          <= '0;
            sticky       <= 1'b0;
            out_valid    <= 1'b0;
            out_real     <= '0;
            out_img      <= '0;
            out_overflow <= 1'b0;
            out_count    <= '0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (accept) begin
                        acc_re <= nxt_re;
                        acc_im <= nxt_im;
                        cnt    <= nxt_cnt;
                        sticky <= nxt_sticky;
                        state  <= close ? HOLD : ACC;
                        if (close) begin
                            out_valid    <= 1'b1;
                            out_real     <= to_out(nxt_re);
                            out_img      <= to_out(nxt_im);
                            out_overflow <= nxt_sticky | range_ovf(nxt_re) | range_ovf(nxt_im);
                            out_count    <= nxt_cnt;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmac_accum_sign.sv
// Directed table-driven bench for cmac_accum_sign at DATA_W=16, N_TERMS=4, GUARD_W=4.
module tb_cmac_accum_sign;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_ovf, in_last;
    logic [15:0] in_real, in_img;
    logic        out_valid, out_ready, out_overflow;
    logic [15:0] out_real, out_img;
    logic [2:0]  out_count;

    int n_checks = 0;
    int n_fail   = 0;

    cmac_accum_sign #(.DATA_W(16), .N_TERMS(4), .GUARD_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_img(in_img), .in_ovf(in_ovf), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_img(out_img),
        .out_overflow(out_overflow), .out_count(out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               nb;
        logic [3:0][15:0] re;
        logic [3:0][15:0] im;
        logic [3:0]       ovf;
        bit               use_last;
        logic [15:0]      exp_re;
        logic [15:0]      exp_im;
        bit               exp_ovf;
        int               exp_cnt;
    } vec_t;

    vec_t vt[8];

    function automatic vec_t mk(int nb, logic [63:0] re, logic [63:0] im, logic [3:0] ovf,
                                bit ul, logic [15:0] er, logic [15:0] ei, bit eo, int ec);
        vec_t v;
        v.nb = nb; v.re = re; v.im = im; v.ovf = ovf; v.use_last = ul;
        v.exp_re = er; v.exp_im = ei; v.exp_ovf = eo; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one beat and wait (bounded) for it to be accepted; returns at clock edge + 1.
    task automatic beat(input logic [15:0] r, input logic [15:0] i, input logic o, input logic l);
        int guard;
        guard = 0;
        in_valid = 1'b1; in_real = r; in_img = i; in_ovf = o; in_last = l;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; in_ovf = 1'b0;
    endtask

    task automatic send_frame(input int k);
        for (int b = 0; b < vt[k].nb; b++) begin
            beat(vt[k].re[b], vt[k].im[b], vt[k].ovf[b], vt[k].use_last && (b == vt[k].nb - 1));
            if (b < vt[k].nb - 1) check($sformatf("v%0d_busy_valid", k), 32'(out_valid), 32'd0);
        end
    endtask

    task automatic check_result(input int k);
        check($sformatf("v%0d_out_valid", k), 32'(out_valid), 32'd1);
        check($sformatf("v%0d_in_ready", k), 32'(in_ready), 32'd0);
        check($sformatf("v%0d_real", k), 32'(out_real), 32'(vt[k].exp_re));
        check($sformatf("v%0d_img", k), 32'(out_img), 32'(vt[k].exp_im));
        check($sformatf("v%0d_ovf", k), 32'(out_overflow), 32'(vt[k].exp_ovf));
        check($sformatf("v%0d_count", k), 32'(out_count), 32'(vt[k].exp_cnt));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_hs_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] big_re, neg_re, big_im;
`ifdef CMAC_ACCUM_SAT_EN
        big_re = 16'h7FFF; neg_re = 16'hFFFF; big_im = 16'h7FFF;
`else
        big_re = 16'h0000; neg_re = 16'h0000; big_im = 16'h4000;
`endif
        vt[0] = mk(3, {16'h0, 16'h0001, 16'h8005, 16'h0003}, {16'h0, 16'h0000, 16'h8001, 16'h0002},
                   4'b0000, 1, 16'h8001, 16'h0001, 0, 3);
        vt[1] = mk(4, {4{16'h4000}}, 64'h0, 4'b0000, 0, big_re, 16'h0000, 1, 4);
        vt[2] = mk(2, {32'h0, 16'h8007, 16'h0007}, 64'h0, 4'b0000, 1, 16'h0000, 16'h0000, 0, 2);
        vt[3] = mk(2, {32'h0, 16'h0003, 16'h0001}, 64'h0, 4'b0001, 1, 16'h0004, 16'h0000, 1, 2);
        vt[4] = mk(1, {48'h0, 16'h0002}, 64'h0, 4'b0000, 1, 16'h0002, 16'h0000, 0, 1);
        vt[5] = mk(4, {4{16'hC000}}, 64'h0, 4'b0000, 0, neg_re, 16'h0000, 1, 4);
        vt[6] = mk(4, {4{16'h0001}}, {4{16'h5000}}, 4'b0000, 0, 16'h0004, big_im, 1, 4);
        vt[7] = mk(2, {32'h0, 16'h0005, 16'h8000}, {32'h0, 16'h8000, 16'h8000}, 4'b0000, 1,
                   16'h0005, 16'h0000, 0, 2);

        in_valid = 0; in_real = 0; in_img = 0; in_ovf = 0; in_last = 0; out_ready = 0;
        rst = 1'b1;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_real", 32'(out_real), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 8; k++) begin
            send_frame(k);
            check_result(k);
            handshake($sformatf("v%0d", k));
        end

        // Result held under back-pressure; beats offered in HOLD must not be consumed.
        beat(16'h0010, 16'h0020, 1'b0, 1'b0);
        beat(16'h0010, 16'h0000, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0]; in_real = 16'h7777; in_img = 16'h7777; in_last = 1'b1;
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_real", 32'(out_real), 32'h0020);
            check("hold_img", 32'(out_img), 32'h0020);
            check("hold_count", 32'(out_count), 32'd2);
        end
        in_valid = 1'b0; in_last = 1'b0;
        handshake("hold");
        send_frame(4);
        check_result(4);
        handshake("after_hold");

        // Reset mid-frame discards the partial sum.
        beat(16'h0005, 16'h0005, 1'b1, 1'b0);
        beat(16'h0005, 16'h0005, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_real", 32'(out_real), 32'd0);
        check("midrst_img", 32'(out_img), 32'd0);
        check("midrst_ovf", 32'(out_overflow), 32'd0);
        check("midrst_count", 32'(out_count), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        beat(16'h0009, 16'h0000, 1'b0, 1'b1);
        check("postrst_valid", 32'(out_valid), 32'd1);
        check("postrst_real", 32'(out_real), 32'h0009);
        check("postrst_count", 32'(out_count), 32'd1);
        check("postrst_ovf", 32'(out_overflow), 32'd0);
        handshake("postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
